dec_by_value: RTL and testbench
===============================

Name: dec_by_value

Overview:
- Down-counting companion to the team's increment-by-value counter. It spends a credit count by a programmable step on each decrement request.
- Provides a per-request accept/reject handshake, zero and underflow flags, and a parallel load.
- Sits on the consumer side of a credit path: the producer adds credits by value, this block removes them.

Parameters:
- WIDTH, 8, width of counter cnt and load_val
- VAL_W, 3, width of step input val
- INIT, 8'd64, reset value of cnt (must fit in WIDTH)
- WRAP_EN, 0, 0 = saturate at zero on underflow, 1 = modulo-2^WIDTH wrap on underflow

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- load  input  1  parallel-load strobe, sampled on posedge clk
- load_val  input  WIDTH  value loaded into cnt
- dec  input  1  decrement request, level; one request per rising level
- val  input  VAL_W  decrement step, sampled with the accepted dec
- cnt  output  WIDTH  current count, registered
- zero  output  1  registered, high when cnt==0
- underflow  output  1  sticky, set when an accepted step exceeded cnt
- ack  output  1  one-cycle pulse, request applied
- nack  output  1  one-cycle pulse, request rejected (saturate mode only)

Behaviour:
- Reset (async, immediate, any state): cnt=INIT, zero=(INIT==0), underflow=0, ack=0, nack=0, FSM=IDLE.
- FSM states:
  - IDLE: dec==1 -> request captured, go to WAIT_LOW.
  - WAIT_LOW: dec ignored; dec==0 -> IDLE.
  - Holding dec high for N cycles therefore yields exactly one decrement.
- Accepted request (IDLE, dec==1, load==0), applied at the same posedge; ack/nack asserted the cycle after that edge for exactly one cycle:
  - val<=cnt: cnt<=cnt-val, ack=1.
  - val>cnt, WRAP_EN=0: cnt<=0, underflow<=1, nack=1.
  - val>cnt, WRAP_EN=1: cnt<=(cnt-val) mod 2^WIDTH, underflow<=1, ack=1.
  - val==0: cnt unchanged, ack=1.
- Width: val is zero-extended to WIDTH before compare/subtract; the comparison is unsigned.
- Latency: cnt, zero, ack, nack, underflow all update on the same edge (single-cycle latency); zero always matches cnt as registered.
- Load: on posedge with load==1, cnt<=load_val and underflow<=0.
  - Load has priority over dec: a simultaneous dec rising edge is consumed (FSM -> WAIT_LOW), with no ack/nack and no subtraction.
  - Load in WAIT_LOW does not change FSM.
- ack and nack are never high together; at most one pulse per accepted request.
- Back-to-back: dec low for one cycle then high again is a new request (minimum two-cycle request period).
- No counter update other than reset, load, or accepted request.

Test Plan:
- Release reset after 10 ns -> cnt=64, zero=0, underflow=0, ack=nack=0; assert rst mid-request -> cnt=64 immediately, no clock needed.
- dec=1 for one cycle with val=3 -> cnt 64->61, ack pulse one cycle; then val=7 -> 54, ack.
- dec held high 4 cycles, val=5, from cnt=54 -> single update to 49, one ack; release and repulse val=1 -> 48.
- WRAP_EN=0: load 2, then dec val=7 -> cnt=0, zero=1, underflow=1, nack pulse, no ack; next dec val=0 -> cnt=0, ack; load 9 -> underflow=0, zero=0.
- WRAP_EN=1: load 2, dec val=7 -> cnt=251, underflow=1, ack, zero=0; load 3, dec val=3 -> cnt=0, zero=1, ack.
- load=1 load_val=10 and dec rising edge same cycle, val=4 -> cnt=10, no ack/nack; dec stays high 2 cycles -> cnt stays 10; release, repulse val=4 -> cnt=6, ack.

Source files
------------

// File: rtl/dec_by_value.sv
// dec_by_value: credit down-counter, one step of val per rising dec level, with load, zero, underflow and ack/nack
module dec_by_value #(
  parameter int WIDTH = 8,
  parameter int VAL_W = 3,
  parameter logic [WIDTH-1:0] INIT = 8'd64,
  parameter bit WRAP_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  input  logic [VAL_W-1:0] val,
  output logic [WIDTH-1:0] cnt,
  output logic             zero,
  output logic             underflow,
  output logic             ack,
  output logic             nack
);
  typedef enum logic {IDLE, WAIT_LOW} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] val_x, cnt_nx;
  logic take, over;
  always_comb begin
    val_x = WIDTH'(val);
    take = (state == IDLE) && dec && !load;
    over = val_x > cnt;
    state_nx = dec ? WAIT_LOW : IDLE;
    cnt_nx = load ? load_val : take ? ((over && !WRAP_EN) ? '0 : cnt - val_x) : cnt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= INIT;
      zero <= (INIT == '0);
      underflow <= 1'b0;
      ack <= 1'b0;
      nack <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      zero <= (cnt_nx == '0);
      underflow <= !load && (underflow || (take && over));
      ack <= take && (!over || WRAP_EN);
      nack <= take && over && !WRAP_EN;
    end
  end
endmodule

// File: tb/tb_dec_by_value.sv
// tb_dec_by_value: directed checks of a saturating (u0) and a wrapping (u1) instance on shared stimulus
module tb_dec_by_value;
  logic clk = 1'b0, rst = 1'b1, load = 1'b0, dec = 1'b0;
  logic [7:0] load_val = '0;
  logic [2:0] val = '0;
  logic [7:0] cnt0, cnt1;
  logic zero0, zero1, uf0, uf1, ack0, ack1, nack0, nack1;
  int checks = 0, errors = 0;

  dec_by_value #(.WIDTH(8), .VAL_W(3), .INIT(8'd64), .WRAP_EN(1'b0)) u0 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .dec(dec), .val(val),
    .cnt(cnt0), .zero(zero0), .underflow(uf0), .ack(ack0), .nack(nack0));
  dec_by_value #(.WIDTH(8), .VAL_W(3), .INIT(8'd64), .WRAP_EN(1'b1)) u1 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .dec(dec), .val(val),
    .cnt(cnt1), .zero(zero1), .underflow(uf1), .ack(ack1), .nack(nack1));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #10 rst = 1'b0;
    #1;
    checks++; if (cnt0 !== 8'd64) begin errors++; $display("FAIL reset_cnt0 got %0d exp 64", cnt0); end
    checks++; if (cnt1 !== 8'd64) begin errors++; $display("FAIL reset_cnt1 got %0d exp 64", cnt1); end
    checks++; if (zero0 !== 1'b0) begin errors++; $display("FAIL reset_zero got %b exp 0", zero0); end
    checks++; if (uf0 !== 1'b0) begin errors++; $display("FAIL reset_uf got %b exp 0", uf0); end
    checks++; if ({ack0, nack0} !== 2'b00) begin errors++; $display("FAIL reset_acknack got %b exp 00", {ack0, nack0}); end
  endtask

  task automatic test_dec;
    val = 3'd3; dec = 1'b1; tick;
    checks++; if (cnt0 !== 8'd61) begin errors++; $display("FAIL dec3_cnt got %0d exp 61", cnt0); end
    checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL dec3_ack got %b exp 1", ack0); end
    dec = 1'b0; tick;
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL dec3_ack_pulse got %b exp 0", ack0); end
    val = 3'd7; dec = 1'b1; tick;
    checks++; if (cnt0 !== 8'd54) begin errors++; $display("FAIL dec7_cnt got %0d exp 54", cnt0); end
    checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL dec7_ack got %b exp 1", ack0); end
    dec = 1'b0; tick;
  endtask

  task automatic test_hold;
    int acks = 0;
    val = 3'd5; dec = 1'b1;
    for (int i = 0; i < 4; i++) begin tick; acks += int'(ack0); end
    checks++; if (cnt0 !== 8'd49) begin errors++; $display("FAIL hold_cnt got %0d exp 49", cnt0); end
    checks++; if (acks != 1) begin errors++; $display("FAIL hold_acks got %0d exp 1", acks); end
    dec = 1'b0; tick;
    val = 3'd1; dec = 1'b1; tick;
    checks++; if (cnt0 !== 8'd48) begin errors++; $display("FAIL repulse_cnt got %0d exp 48", cnt0); end
    checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL repulse_ack got %b exp 1", ack0); end
    dec = 1'b0; tick;
  endtask

  task automatic test_async_reset;
    val = 3'd2; dec = 1'b1; tick;
    checks++; if (cnt0 !== 8'd46) begin errors++; $display("FAIL prereset_cnt got %0d exp 46", cnt0); end
    #2 rst = 1'b1;
    #1;
    checks++; if (cnt0 !== 8'd64) begin errors++; $display("FAIL async_rst_cnt got %0d exp 64", cnt0); end
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL async_rst_ack got %b exp 0", ack0); end
    rst = 1'b0; dec = 1'b0; tick;
  endtask

  task automatic test_underflow;
    load = 1'b1; load_val = 8'd2; tick;
    load = 1'b0;
    checks++; if (cnt0 !== 8'd2 || cnt1 !== 8'd2) begin errors++; $display("FAIL load2 got %0d/%0d exp 2/2", cnt0, cnt1); end
    val = 3'd7; dec = 1'b1; tick;
    checks++; if (cnt0 !== 8'd0) begin errors++; $display("FAIL sat_cnt got %0d exp 0", cnt0); end
    checks++; if ({zero0, uf0} !== 2'b11) begin errors++; $display("FAIL sat_zero_uf got %b exp 11", {zero0, uf0}); end
    checks++; if ({ack0, nack0} !== 2'b01) begin errors++; $display("FAIL sat_acknack got %b exp 01", {ack0, nack0}); end
    checks++; if (cnt1 !== 8'd251) begin errors++; $display("FAIL wrap_cnt got %0d exp 251", cnt1); end
    checks++; if ({zero1, uf1, ack1, nack1} !== 4'b0110) begin errors++; $display("FAIL wrap_flags got %b exp 0110", {zero1, uf1, ack1, nack1}); end
    dec = 1'b0; tick;
    checks++; if ({nack0, ack1, uf0} !== 3'b001) begin errors++; $display("FAIL after_uf got %b exp 001", {nack0, ack1, uf0}); end
    val = 3'd0; dec = 1'b1; tick;
    checks++; if (cnt0 !== 8'd0 || ack0 !== 1'b1 || nack0 !== 1'b0) begin errors++; $display("FAIL val0 got cnt %0d ack %b nack %b exp 0 1 0", cnt0, ack0, nack0); end
    checks++; if (cnt1 !== 8'd251 || ack1 !== 1'b1) begin errors++; $display("FAIL val0_wrap got cnt %0d ack %b exp 251 1", cnt1, ack1); end
    dec = 1'b0; tick;
    load = 1'b1; load_val = 8'd9; tick;
    load = 1'b0;
    checks++; if ({cnt0, zero0, uf0, uf1} !== {8'd9, 3'b000}) begin errors++; $display("FAIL load9 got cnt %0d zero %b uf %b/%b exp 9 0 0/0", cnt0, zero0, uf0, uf1); end
  endtask

  task automatic test_wrap_exact;
    load = 1'b1; load_val = 8'd3; tick;
    load = 1'b0; val = 3'd3; dec = 1'b1; tick;
    checks++; if ({cnt1, zero1, ack1, uf1} !== {8'd0, 3'b110}) begin errors++; $display("FAIL exact_wrap got cnt %0d zero %b ack %b uf %b exp 0 1 1 0", cnt1, zero1, ack1, uf1); end
    checks++; if ({cnt0, zero0, ack0, nack0} !== {8'd0, 3'b110}) begin errors++; $display("FAIL exact_sat got cnt %0d zero %b ack %b nack %b exp 0 1 1 0", cnt0, zero0, ack0, nack0); end
    dec = 1'b0; tick;
  endtask

  task automatic test_load_priority;
    load = 1'b1; load_val = 8'd10; val = 3'd4; dec = 1'b1; tick;
    load = 1'b0;
    checks++; if (cnt0 !== 8'd10) begin errors++; $display("FAIL prio_cnt got %0d exp 10", cnt0); end
    checks++; if ({ack0, nack0} !== 2'b00) begin errors++; $display("FAIL prio_acknack got %b exp 00", {ack0, nack0}); end
    tick; tick;
    checks++; if (cnt0 !== 8'd10 || ack0 !== 1'b0) begin errors++; $display("FAIL prio_held got cnt %0d ack %b exp 10 0", cnt0, ack0); end
    dec = 1'b0; tick;
    dec = 1'b1; tick;
    checks++; if (cnt0 !== 8'd6 || ack0 !== 1'b1) begin errors++; $display("FAIL prio_repulse got cnt %0d ack %b exp 6 1", cnt0, ack0); end
    dec = 1'b0; tick;
  endtask

  initial begin
    test_reset;
    test_dec;
    test_hold;
    test_async_reset;
    test_underflow;
    test_wrap_exact;
    test_load_priority;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
